// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - sequence checker for a free-running up counter (optional event buffer: COUNT_SEQ_MONITOR_EVT_EN)
module count_seq_monitor #(
    parameter int WIDTH   = 4,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [WIDTH-1:0]   count_in,
    input  logic               clr_err,
    output logic               wrap_pulse,
    output logic [EPOCH_W-1:0] epoch,
    output logic               err,
    output logic [7:0]         err_cnt,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    input  logic               evt_ready,
    output logic               evt_ovf
);

    localparam logic IDLE  = 1'b0;
    localparam logic TRACK = 1'b1;

    logic             state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_val;
    logic             tracking;
    logic             seq_wrap;
    logic             seq_err;

    assign exp_val  = prev + 1'b1;
    assign tracking = en && (state == TRACK);
    assign seq_wrap = tracking && (count_in == exp_val) && (exp_val == '0);
    assign seq_err  = tracking && (count_in != prev) && (count_in != exp_val);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            prev       <= '0;
            wrap_pulse <= 1'b0;
            epoch      <= '0;
            err        <= 1'b0;
            err_cnt    <= 8'd0;
        end else begin
            wrap_pulse <= seq_wrap;
            if (en) begin
                state <= TRACK;
                prev  <= count_in;
            end
            if (seq_wrap) begin
                epoch <= epoch + 1'b1;
            end
            // A fresh error outranks a simultaneous clear so it is never lost.
            if (seq_err) begin
                err     <= 1'b1;
                err_cnt <= clr_err ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
            end else if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= 8'd0;
            end
        end
    end

`ifdef COUNT_SEQ_MONITOR_EVT_EN
    logic new_evt;
    logic load_evt;

    assign new_evt  = seq_wrap || seq_err;
    assign load_evt = new_evt && (!evt_valid || evt_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            evt_ovf   <= 1'b0;
        end else begin
            if (load_evt) begin
                evt_valid <= 1'b1;
                evt_code  <= seq_wrap ? 2'b01 : 2'b10;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            if (clr_err) begin
                evt_ovf <= 1'b0;
            end else if (new_evt && !load_evt) begin
                evt_ovf <= 1'b1;
            end
        end
    end
`else
    logic unused_evt_ready;

    assign unused_evt_ready = evt_ready;
    assign evt_valid        = 1'b0;
    assign evt_code         = 2'b00;
    assign evt_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb/tb_count_seq_monitor.sv - randomized and directed bench for count_seq_monitor against a behavioural model
module tb_count_seq_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [3:0] count_in = 4'd0;
    logic       clr_err = 1'b0;
    logic       wrap_pulse;
    logic [7:0] epoch;
    logic       err;
    logic [7:0] err_cnt;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready = 1'b1;
    logic       evt_ovf;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model state
    bit m_ref;
    int m_prev;
    int m_epoch;
    bit m_err;
    int m_errcnt;
    bit m_wrap;
    bit m_valid;
    int m_code;
    bit m_ovf;

    count_seq_monitor #(.WIDTH(4), .EPOCH_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in), .clr_err(clr_err),
        .wrap_pulse(wrap_pulse), .epoch(epoch), .err(err), .err_cnt(err_cnt),
        .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready), .evt_ovf(evt_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_ref = 0; m_prev = 0; m_epoch = 0; m_err = 0; m_errcnt = 0;
        m_wrap = 0; m_valid = 0; m_code = 0; m_ovf = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(m_wrap));
        check({tag, ".epoch"}, 32'(epoch), 32'(m_epoch));
        check({tag, ".err"}, 32'(err), 32'(m_err));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_errcnt));
        check({tag, ".evt_valid"}, 32'(evt_valid), 32'(m_valid));
        if (m_valid) check({tag, ".evt_code"}, 32'(evt_code), 32'(m_code));
        check({tag, ".evt_ovf"}, 32'(evt_ovf), 32'(m_ovf));
    endtask

    task automatic model_step(input bit e, input int c, input bit rdy, input bit clr);
        bit is_wrap, is_err;
        is_wrap = 0; is_err = 0;
        if (e) begin
            if (m_ref) begin
                if (c == m_prev) ;
                else if (c == (m_prev + 1) % 16) is_wrap = (c == 0);
                else is_err = 1;
            end
            m_ref  = 1;
            m_prev = c;
        end
        m_wrap = is_wrap;
        if (is_wrap) m_epoch = (m_epoch + 1) % 256;
        if (is_err) begin
            m_err = 1;
            m_errcnt = clr ? 1 : ((m_errcnt < 255) ? m_errcnt + 1 : 255);
        end else if (clr) begin
            m_err = 0;
            m_errcnt = 0;
        end
`ifdef COUNT_SEQ_MONITOR_EVT_EN
        if (is_wrap || is_err) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_code = is_wrap ? 1 : 2;
            end else begin
                m_ovf = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (clr) m_ovf = 0;
`endif
    endtask

    task automatic step(input bit e, input int c, input bit rdy, input bit clr, input string tag);
        @(negedge clk);
        en = e; count_in = 4'(c); evt_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_step(e, c, rdy, clr);
        #1;
        compare_all(tag);
    endtask

    task automatic run_range(input int lo, input int hi, input bit rdy, input string tag);
        for (int v = lo; v <= hi; v++) step(1, v, rdy, 0, tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        repeat (2) @(negedge clk);
        en = 0; clr_err = 0; evt_ready = 1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        en = 0; count_in = 0; clr_err = 0; evt_ready = 1;
        #20;
        compare_all("reset_init");
        @(negedge clk);
        reset = 1'b1;

        // Single wrap
        run_range(0, 15, 1, "wrap_up");
        step(1, 0, 0, 0, "wrap_zero");
        check("wrap.pulse", 32'(wrap_pulse), 32'd1);
        check("wrap.epoch", 32'(epoch), 32'd1);
        check("wrap.err", 32'(err), 32'd0);
`ifdef COUNT_SEQ_MONITOR_EVT_EN
        check("wrap.evt_valid", 32'(evt_valid), 32'd1);
        check("wrap.evt_code", 32'(evt_code), 32'd1);
`endif
        step(1, 0, 1, 0, "wrap_after");
        check("wrap.pulse_once", 32'(wrap_pulse), 32'd0);

        // Epoch counting, including rollover of the epoch counter
        run_range(1, 15, 1, "epoch2_up");
        step(1, 0, 1, 0, "epoch2_zero");
        check("epoch.two", 32'(epoch), 32'd2);
        for (int w = 0; w < 258; w++) begin
            run_range(1, 15, 1, "epoch_many_up");
            step(1, 0, 1, 0, "epoch_many_zero");
        end
        check("epoch.mod256", 32'(epoch), 32'd4);

        // Sequence error and resynchronisation
        apply_reset("reset_seq");
        step(1, 4, 1, 0, "seq_4");
        step(1, 5, 1, 0, "seq_5");
        step(1, 9, 0, 0, "seq_9");
        check("seq.err", 32'(err), 32'd1);
        check("seq.err_cnt", 32'(err_cnt), 32'd1);
`ifdef COUNT_SEQ_MONITOR_EVT_EN
        check("seq.evt_code", 32'(evt_code), 32'd2);
`endif
        step(1, 10, 1, 0, "seq_10");
        check("seq.resync", 32'(err_cnt), 32'd1);

        // Hold, and disabled jumps
        step(1, 11, 1, 1, "clr");
        step(1, 11, 1, 0, "hold_a");
        step(1, 11, 1, 0, "hold_b");
        step(1, 12, 1, 0, "hold_c");
        step(0, 3, 1, 0, "en_off_a");
        step(0, 9, 1, 0, "en_off_b");
        step(1, 13, 1, 0, "en_on");
        check("hold_en.no_err", 32'(err), 32'd0);

        // Backpressure across two wraps
        run_range(14, 15, 0, "bp_up");
        step(1, 0, 0, 0, "bp_wrap1");
        run_range(1, 15, 0, "bp_up2");
        step(1, 0, 0, 0, "bp_wrap2");
`ifdef COUNT_SEQ_MONITOR_EVT_EN
        check("bp.evt_ovf", 32'(evt_ovf), 32'd1);
        check("bp.evt_valid", 32'(evt_valid), 32'd1);
`endif
        step(1, 7, 0, 0, "bp_err");
        step(1, 7, 1, 1, "bp_clr");
        check("bp.clr_err", 32'(err), 32'd0);
        check("bp.clr_ovf", 32'(evt_ovf), 32'd0);
        step(1, 7, 1, 0, "bp_drain");

        // Mid-operation reset with epoch=3, err=1, pending event
        apply_reset("reset_mid_pre");
        for (int w = 0; w < 3; w++) begin
            run_range((w == 0) ? 0 : 1, 15, 0, "mid_up");
            step(1, 0, 0, 0, "mid_wrap");
        end
        step(1, 5, 0, 0, "mid_err");
        check("mid.epoch", 32'(epoch), 32'd3);
        apply_reset("reset_mid");
        step(1, 12, 1, 0, "mid_ref12");
        step(1, 13, 1, 0, "mid_13");
        check("mid.no_err", 32'(err), 32'd0);

        // Saturation of err_cnt
        for (int k = 0; k < 300; k++) step(1, (m_prev + 5) % 16, 1, 0, "sat");
        check("sat.err_cnt", 32'(err_cnt), 32'd255);

        // Randomized traffic, clr_err occasionally
        step(1, m_prev, 1, 1, "rnd_clr");
        for (int k = 0; k < 3000; k++) begin
            int r, c;
            r = int'($urandom_range(0, 9));
            if (r < 6)      c = (m_prev + 1) % 16;
            else if (r < 8) c = m_prev;
            else            c = int'($urandom_range(0, 15));
            step(($urandom_range(0, 7) != 0), c, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 40) == 0), "rnd");
            if ($urandom_range(0, 999) == 0) apply_reset("rnd_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
